// File: rtl/core_pkg.sv
// Shared definitions for the core instruction bus: field positions, the idle
// instruction word and the sequencer state encoding.
package core_pkg;

    localparam int INST_W      = 34;
    localparam int ADDR_W      = 11;
    localparam int T_W         = 11;

    localparam int ACC_B       = 33;
    localparam int CEN_PMEM_B  = 32;
    localparam int WEN_PMEM_B  = 31;
    localparam int A_PMEM_MSB  = 30;
    localparam int A_PMEM_LSB  = 20;
    localparam int CEN_XMEM_B  = 19;
    localparam int WEN_XMEM_B  = 18;
    localparam int A_XMEM_MSB  = 17;
    localparam int A_XMEM_LSB  = 7;
    localparam int OFIFO_RD_B  = 6;
    localparam int IFIFO_WR_B  = 5;
    localparam int IFIFO_RD_B  = 4;
    localparam int L0_RD_B     = 3;
    localparam int L0_WR_B     = 2;
    localparam int EXECUTE_B   = 1;
    localparam int LOAD_B      = 0;

    // Both memories deselected (active-low CEN/WEN high), everything else quiet.
    localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_L0    = 4'd1,
        S_PE_LOAD = 4'd2,
        S_GAP     = 4'd3,
        S_A_L0    = 4'd4,
        S_EXEC    = 4'd5,
        S_OREAD   = 4'd6,
        S_NEXT    = 4'd7,
        S_DONE    = 4'd8
    } seq_state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable up-counter with enable and a terminal-count flag; provides the
// per-state phase index t of the sequencer.
module phase_counter
    import core_pkg::*;
#(
    parameter int W = T_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Phase register: load wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == term);

endmodule

// File: rtl/kij_sequencer.sv
// Drives the core instruction bus through weight staging, PE load, activation
// staging, execution and OFIFO drain for every kernel position of a 3x3 tile.
module kij_sequencer
    import core_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 64,
    parameter int len_kij = 9,
    parameter int gap     = 10,
    parameter int w_base  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij
);

    if (row < 1 || col < 1 || gap < 1 || len_nij < 1 || len_kij < 1 || len_kij > 16 ||
        w_base + len_kij * col > 2048 || len_kij * len_nij > 2048) begin : g_bad_cfg
        $error("kij_sequencer: parameters do not fit the 11-bit address fields");
    end

    seq_state_e        state_r;
    logic [3:0]        kij_r;
    logic [INST_W-1:0] inst_r;
    logic              busy_r;
    logic              done_r;

    logic [T_W-1:0]    t_s;
    logic              tc_s;
    logic [T_W-1:0]    term_s;
    logic              adv_s;
    logic              en_s;
    logic [INST_W-1:0] word_s;
    logic [ADDR_W-1:0] addr_w_s;
    logic [ADDR_W-1:0] addr_p_s;

    phase_counter #(.W(T_W)) u_phase (
        .clk      (clk),
        .rst      (reset),
        .load     (adv_s),
        .en       (en_s),
        .load_val ({T_W{1'b0}}),
        .term     (term_s),
        .cnt      (t_s),
        .tc       (tc_s)
    );

    assign addr_w_s = ADDR_W'(w_base) + ADDR_W'(kij_r) * ADDR_W'(col) + t_s;
    assign addr_p_s = ADDR_W'(kij_r) * ADDR_W'(len_nij) + t_s;

    // Phase length per state and the condition that leaves it (restarts t).
    always_comb begin
        term_s = {T_W{1'b0}};
        adv_s  = 1'b0;
        en_s   = 1'b1;
        case (state_r)
            S_IDLE:    begin adv_s = start; en_s = 1'b0; end
            S_W_L0:    begin term_s = T_W'(col);         adv_s = tc_s; end
            S_PE_LOAD: begin term_s = T_W'(col - 1);     adv_s = tc_s; end
            S_GAP:     begin term_s = T_W'(gap - 1);     adv_s = tc_s; end
            S_A_L0:    begin term_s = T_W'(len_nij);     adv_s = tc_s; end
            S_EXEC:    begin term_s = T_W'(len_nij - 1); adv_s = tc_s; end
            S_OREAD:   begin
                term_s = T_W'(len_nij - 1);
                adv_s  = tc_s && ofifo_valid;
                en_s   = ofifo_valid;
            end
            S_NEXT:    begin adv_s = 1'b1; en_s = 1'b0; end
            S_DONE:    begin adv_s = 1'b1; en_s = 1'b0; end
            default:   begin adv_s = 1'b1; en_s = 1'b0; end
        endcase
    end

    // Instruction word for the current state and phase; l0_wr trails the
    // SRAM read by one cycle to cover its read latency.
    always_comb begin
        word_s             = IDLE_WORD;
        word_s[ACC_B]      = 1'b0;
        word_s[IFIFO_WR_B] = 1'b0;
        word_s[IFIFO_RD_B] = 1'b0;
        case (state_r)
            S_W_L0, S_A_L0: begin
                if (t_s < ((state_r == S_W_L0) ? T_W'(col) : T_W'(len_nij))) begin
                    word_s[CEN_XMEM_B]                = 1'b0;
                    word_s[WEN_XMEM_B]                = 1'b1;
                    word_s[A_XMEM_MSB:A_XMEM_LSB]     = (state_r == S_W_L0) ? addr_w_s : t_s;
                end else begin
                    word_s[CEN_XMEM_B]                = 1'b1;
                end
                if (t_s != {T_W{1'b0}}) begin
                    word_s[L0_WR_B] = 1'b1;
                end else begin
                    word_s[L0_WR_B] = 1'b0;
                end
            end
            S_PE_LOAD: begin
                word_s[L0_RD_B] = 1'b1;
                word_s[LOAD_B]  = 1'b1;
            end
            S_EXEC: begin
                word_s[L0_RD_B]    = 1'b1;
                word_s[EXECUTE_B]  = 1'b1;
            end
            S_OREAD: begin
                if (ofifo_valid) begin
                    word_s[OFIFO_RD_B]            = 1'b1;
                    word_s[CEN_PMEM_B]            = 1'b0;
                    word_s[WEN_PMEM_B]            = 1'b0;
                    word_s[A_PMEM_MSB:A_PMEM_LSB] = addr_p_s;
                end else begin
                    word_s[OFIFO_RD_B]            = 1'b0;
                end
            end
            default: word_s = IDLE_WORD;
        endcase
    end

    // Main FSM with registered instruction, status and kernel index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            kij_r   <= 4'd0;
            inst_r  <= IDLE_WORD;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            inst_r <= word_s;
            busy_r <= (state_r != S_IDLE);
            done_r <= (state_r == S_DONE);
            case (state_r)
                S_IDLE: begin
                    kij_r <= 4'd0;
                    if (start) begin
                        state_r <= S_W_L0;
                    end
                end
                S_W_L0:    if (tc_s) state_r <= S_PE_LOAD;
                S_PE_LOAD: if (tc_s) state_r <= S_GAP;
                S_GAP:     if (tc_s) state_r <= S_A_L0;
                S_A_L0:    if (tc_s) state_r <= S_EXEC;
                S_EXEC:    if (tc_s) state_r <= S_OREAD;
                S_OREAD:   if (tc_s && ofifo_valid) state_r <= S_NEXT;
                S_NEXT: begin
                    if (kij_r == 4'(len_kij - 1)) begin
                        state_r <= S_DONE;
                    end else begin
                        kij_r   <= kij_r + 4'd1;
                        state_r <= S_W_L0;
                    end
                end
                S_DONE: begin
                    kij_r   <= 4'd0;
                    state_r <= S_IDLE;
                end
                default: begin
                    kij_r   <= 4'd0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign inst = inst_r;
    assign busy = busy_r;
    assign done = done_r;
    assign kij  = kij_r;

endmodule

// File: tb/tb_kij_sequencer.sv
// Self-checking bench for kij_sequencer: a loop-structured reference model of
// the instruction stream compared every cycle, plus literal spot checks.
module tb_kij_sequencer;

    localparam int COL = 8;
    localparam int NIJ = 64;
    localparam int KIJ = 9;
    localparam int GAP = 10;
    localparam int WB  = 1024;
    localparam logic [33:0] IDLE_LIT = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    always #5 clk = ~clk;

    kij_sequencer #(
        .row(8), .col(COL), .len_nij(NIJ), .len_kij(KIJ), .gap(GAP), .w_base(WB)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .kij(kij)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word assembled from named fields.
    function automatic logic [33:0] mkw(bit xrd, int ax, bit l0wr, bit l0rd, bit ld,
                                        bit ex, bit prd, int ap);
        logic [10:0] axw;
        logic [10:0] apw;
        axw = 11'(ax);
        apw = 11'(ap);
        return {1'b0, ~prd, ~prd, apw, ~xrd, 1'b1, axw, prd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
    endfunction

    // ---------------- reference model ----------------
    logic [33:0] exp_inst = IDLE_LIT;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [3:0]  exp_kij  = 4'd0;
    bit          m_abort  = 1'b0;

    task automatic set_idle();
        exp_inst = mkw(0, 0, 0, 0, 0, 0, 0, 0);
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_kij  = 4'd0;
    endtask

    task automatic step(input logic [33:0] w, input int k, input bit d);
        if (m_abort) return;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_abort = 1'b1;
            set_idle();
            return;
        end
        exp_inst = w;
        exp_busy = 1'b1;
        exp_done = d;
        exp_kij  = 4'(k);
    endtask

    task automatic ostep(input int k, input int t, output bit adv);
        adv = 1'b1;
        if (m_abort) return;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_abort = 1'b1;
            set_idle();
            return;
        end
        adv      = ofifo_valid;
        exp_inst = ofifo_valid ? mkw(0, 0, 0, 0, 0, 0, 1, k * NIJ + t) : mkw(0, 0, 0, 0, 0, 0, 0, 0);
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_kij  = 4'(k);
    endtask

    task automatic run_model();
        bit adv;
        int t;
        m_abort = 1'b0;
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i <= COL; i++)
                step(mkw(i < COL, (i < COL) ? WB + k * COL + i : 0, i >= 1, 0, 0, 0, 0, 0), k, 0);
            for (int i = 0; i < COL; i++) step(mkw(0, 0, 0, 1, 1, 0, 0, 0), k, 0);
            for (int i = 0; i < GAP; i++) step(mkw(0, 0, 0, 0, 0, 0, 0, 0), k, 0);
            for (int i = 0; i <= NIJ; i++)
                step(mkw(i < NIJ, (i < NIJ) ? i : 0, i >= 1, 0, 0, 0, 0, 0), k, 0);
            for (int i = 0; i < NIJ; i++) step(mkw(0, 0, 0, 1, 0, 1, 0, 0), k, 0);
            t = 0;
            while (t < NIJ && !m_abort) begin
                ostep(k, t, adv);
                if (adv) t++;
            end
            step(mkw(0, 0, 0, 0, 0, 0, 0, 0), (k < KIJ - 1) ? k + 1 : k, 0);
            if (m_abort) return;
        end
        step(mkw(0, 0, 0, 0, 0, 0, 0, 0), 0, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            set_idle();
            if (!reset && start) run_model();
        end
    end

    // ---------------- per-cycle compare and statistics ----------------
    bit          chk_en = 1'b0;
    int          run_id = 0;
    int          cyc = 0;
    int          first_x = -1, first_l0 = -1, l0_burst = 0, l0_phase = 0;
    int          load_cnt = 0, exec_cnt = 0, done_cyc = -1;
    logic [10:0] xq[$];
    logic [10:0] pq[$];
    logic        done_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en)
            check("cycle_outputs", {24'd0, inst, busy, done, kij},
                  {24'd0, exp_inst, exp_busy, exp_done, exp_kij});
        if (chk_en && done_prev && !done) check("busy_falls_with_done", {63'd0, busy}, 64'd0);
        done_prev = done;
        if (run_id == 1) begin
            if (!inst[19]) begin
                xq.push_back(inst[17:7]);
                if (first_x < 0) first_x = cyc;
            end
            if (inst[2] && l0_phase == 0) begin first_l0 = cyc; l0_phase = 1; end
            if (l0_phase == 1) begin
                if (inst[2]) l0_burst++;
                else l0_phase = 2;
            end
            load_cnt += int'(inst[0]);
            exec_cnt += int'(inst[1]);
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        if (run_id == 2 && !inst[31]) pq.push_back(inst[30:20]);
    end

    // ---------------- stimulus ----------------
    bit found;
    int bad;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        start = 1'b1;                       // ignored while in reset
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_inst", {30'd0, inst}, {30'd0, IDLE_LIT});
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_kij",  {60'd0, kij},  64'd0);

        // Run 1: ofifo_valid always high.
        run_id = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        check("run1_done_seen", {63'd0, found}, 64'd1);
        @(negedge clk);
        run_id = 0;
        check("done_latency", 64'(done_cyc - first_x), 64'd1989);
        check("xmem_read_count", 64'(xq.size()), 64'(KIJ * (COL + NIJ)));
        if (xq.size() >= 80) begin
            for (int i = 0; i < 8; i++)  check("xmem_w_kij0", {53'd0, xq[i]}, 64'(1024 + i));
            for (int i = 0; i < 64; i++) check("xmem_act_kij0", {53'd0, xq[8 + i]}, 64'(i));
            for (int i = 0; i < 8; i++)  check("xmem_w_kij1", {53'd0, xq[72 + i]}, 64'(1032 + i));
        end
        check("l0_wr_delay", 64'(first_l0 - first_x), 64'd1);
        check("l0_wr_burst", 64'(l0_burst), 64'd8);
        check("load_cycles", 64'(load_cnt), 64'd72);
        check("exec_cycles", 64'(exec_cnt), 64'd576);

        // Run 2: ofifo_valid toggling every cycle, stray start pulses mid-run.
        repeat (3) @(negedge clk);
        run_id = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            ofifo_valid = ~ofifo_valid;
            start = (i % 300 == 150);
            @(negedge clk);
            if (done) begin found = 1'b1; break; end
        end
        start = 1'b0;
        check("run2_done_seen", {63'd0, found}, 64'd1);
        @(negedge clk);
        run_id = 0;
        check("pmem_write_count", 64'(pq.size()), 64'd576);
        if (pq.size() >= 192)
            for (int i = 128; i < 192; i++) check("pmem_addr_kij2", {53'd0, pq[i]}, 64'(i));
        bad = 0;
        foreach (pq[i]) if (pq[i] != 11'(i)) bad++;
        check("pmem_addr_order", 64'(bad), 64'd0);

        // Run 3: random ofifo_valid, reset during EXEC of kij 4.
        repeat (3) @(negedge clk);
        ofifo_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            ofifo_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (kij == 4'd4 && inst[1]) begin found = 1'b1; break; end
        end
        check("reached_exec_kij4", {63'd0, found}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_inst", {30'd0, inst}, {30'd0, IDLE_LIT});
        check("async_reset_kij",  {60'd0, kij},  64'd0);
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ofifo_valid = 1'b1;
        repeat (2) @(negedge clk);

        // Run 4: restart after reset begins at kij 0, A_xmem 1024.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!inst[19]) begin found = 1'b1; break; end
        end
        check("restart_read_seen", {63'd0, found}, 64'd1);
        check("restart_a_xmem", {53'd0, inst[17:7]}, 64'd1024);
        check("restart_kij", {60'd0, kij}, 64'd0);
        repeat (300) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kij_sequencer.md
# kij_sequencer

Instruction sequencer that drives the 34-bit `inst` bus of `core` for a full 3x3 convolution tile.

- Steps through all `len_kij` kernel positions. For each one it stages weights from xmem into L0, loads the PEs, waits an intermission, stages activations into L0, executes, and drains OFIFO into pmem.
- Sits directly upstream of `core` and replaces the hand-written testbench stimulus.
- Activations (xmem 0..len_nij-1) and weights (xmem `w_base` + kij*col + r) are preloaded into xmem before `start`.

## Interface
Parameters:
- `row`, 8, PE rows (input channels).
- `col`, 8, PE columns; also the number of weight words per kij.
- `len_nij`, 64, activation words per kij.
- `len_kij`, 9, kernel positions.
- `gap`, 10, idle cycles between PE load and activation staging.
- `w_base`, 1024, xmem base address of the weights.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request; ignored unless in IDLE.
- `ofifo_valid` in 1: OFIFO holds a full output row.
- `inst` out 34: registered instruction word. Bit fields:
  - [33] acc
  - [32] CEN_pmem
  - [31] WEN_pmem
  - [30:20] A_pmem
  - [19] CEN_xmem
  - [18] WEN_xmem
  - [17:7] A_xmem
  - [6] ofifo_rd
  - [5] ififo_wr
  - [4] ififo_rd
  - [3] l0_rd
  - [2] l0_wr
  - [1] execute
  - [0] load
  - CEN and WEN are active-low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of the run.
- `kij` out 4: current kernel index.

## Operation
Reset values:
- `inst` = IDLE word 34'h1_800C_0000 (both CEN and WEN high, all else 0).
- `busy` = 0, `done` = 0, `kij` = 0, state = IDLE.

States, with a phase counter `t` cleared on every state entry:
- IDLE: `start` → W_L0, with `kij` = 0.
- W_L0, col+1 cycles:
  - For t<col: xmem read with CEN_xmem=0, WEN_xmem=1, A_xmem = w_base + kij*col + t.
  - l0_wr=1 for t = 1..col, i.e. delayed one cycle to match SRAM read latency.
- PE_LOAD, col cycles: l0_rd=1, load=1.
- GAP, `gap` cycles: IDLE word.
- A_L0, len_nij+1 cycles: xmem reads at A_xmem = t for t<len_nij; l0_wr one cycle delayed.
- EXEC, len_nij cycles: l0_rd=1, execute=1.
- OREAD:
  - In each cycle with `ofifo_valid`=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = kij*len_nij + t, then t++.
  - Cycles with `ofifo_valid`=0 emit the IDLE word and do not advance t.
  - Leave when t reaches len_nij.
- NEXT, 1 cycle:
  - If kij == len_kij-1 → DONE.
  - Otherwise kij++ and → W_L0.
- DONE, 1 cycle: `done`=1, then → IDLE, with `kij` back to 0.

Arithmetic and fixed fields:
- Address math is 11-bit unsigned. The maximum A_pmem is 575 and does not wrap.
- `acc`, `ififo_wr` and `ififo_rd` are always 0.
- All fields not listed for a state take their IDLE values.

Boundary conditions:
- `start` while busy: ignored.
- `reset` mid-run: immediately returns to IDLE, the IDLE word and kij=0. No partial pmem write continues.
- `ofifo_valid` held low indefinitely: the block stays in OREAD. There is no timeout.

## Timing
- `inst` is a register.
- `start` sampled on edge N → first W_L0 word (A_xmem = w_base) is visible after edge N+1.
- Per kij, with `ofifo_valid` continuously high: (col+1) + col + gap + (len_nij+1) + len_nij + len_nij + 1 cycles, which is 221 with the defaults.
- `done` rises 9*221 cycles after the first W_L0 word (1989 with defaults).
- `busy` falls in the same cycle that `done` falls.

## Structure
- A shared package `core_pkg` holds:
  - the inst bit-position localparams (ACC_B=33 … LOAD_B=0);
  - the IDLE word constant;
  - the state enum.
- One sub-module, `phase_counter`: loadable terminal-count counter with enable, used for `t`.
- Everything else is a single FSM plus address generation.

## Test plan
- Reset then idle → `inst`=34'h1_800C_0000, busy=0, kij=0; `start` pulsed during reset is ignored.
- `start` with `ofifo_valid`=1 throughout → A_xmem sequence:
  - 1024..1031, then 0..63 for kij 0;
  - 1032.. for kij 1;
  - `done` pulses exactly 1989 cycles after the first W_L0 word.
- Check the l0_wr alignment:
  - l0_wr is first high one cycle after the first xmem read, and high for exactly col cycles;
  - load and execute are high for exactly 8 and 64 cycles.
- Toggle `ofifo_valid` 1,0,1,0 in OREAD → pmem writes only in valid cycles; A_pmem for kij=2 runs 128..191 with no gaps or repeats.
- Assert `reset` in EXEC of kij 4 → `inst` returns to the IDLE word asynchronously; a subsequent `start` restarts at kij 0, A_xmem 1024.
- `start` pulsed in mid-run → no effect on sequence or cycle count.
